// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt sequencer.
//   pic_state_e : sequencer FSM states
//   OCW2 command codes (ocw2[7:5]), AEOI bit position in ICW4, spurious IR index
package pic_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPend,
      StAck1,
      StAck2
   } pic_state_e;

   localparam logic [2:0] EOI_NS  = 3'b001;
   localparam logic [2:0] EOI_SP  = 3'b011;
   localparam logic [2:0] ROT_NS  = 3'b101;
   localparam logic [2:0] SET_PRI = 3'b110;
   localparam logic [2:0] ROT_SP  = 3'b111;

   localparam int unsigned AEOI_BIT = 1;
   localparam logic [2:0] SPURIOUS_IR = 3'd7;

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver.
// Scans the eight IR levels starting from (lowest_prio_i + 1) mod 8, which is the
// highest priority. A request wins only if no in-service bit of equal or higher
// priority is met first.
//   req_i         : pending, unmasked requests
//   isr_i         : in-service bits that block equal/lower priorities
//   lowest_prio_i : index of the lowest-priority level
//   valid_o       : an eligible request exists
//   winner_o      : index of that request
module pic_priority_resolver (
   input  logic [7:0] req_i,
   input  logic [7:0] isr_i,
   input  logic [2:0] lowest_prio_i,
   output logic       valid_o,
   output logic [2:0] winner_o
);

   logic       done;
   logic [2:0] idx;

   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      done     = 1'b0;
      idx      = '0;
      for (int k = 0; k < 8; k++) begin
         idx = lowest_prio_i + 3'(k) + 3'd1;
         if (!done) begin
            // An in-service bit at this level blocks it and everything below.
            if (isr_i[idx]) begin
               done = 1'b1;
            end else if (req_i[idx]) begin
               valid_o  = 1'b1;
               winner_o = idx;
               done     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// PIC interrupt sequencer: priority resolution, INT generation, 8086-mode two-pulse
// INTA sequence, vector drive and ISR maintenance (EOI / AEOI).
// Optional macro PIC_ROTATE_PRIORITY_EN adds rotating priority (OCW2 codes
// 101/110/111 and rotate-in-AEOI); without it priority is fixed, IR0 highest.
// Ports:
//   clk_i, rst_ni         : clock, async active-low reset
//   init_done_i           : ICW sequence complete; low holds the block idle
//   irr_i, imr_i          : request and mask registers
//   icw2_i, icw4_i        : vector base, AEOI select (bit1)
//   ocw2_i, ocw2_change_i : OCW2 and its newly-written level flag
//   ocw3_i                : bits[1:0] status select
//   inta_n_i              : asynchronous interrupt acknowledge, active low
//   int_o                 : interrupt request to CPU
//   irr_clr_o             : one-cycle clear of the acknowledged IRR bit
//   isr_o                 : in-service register
//   vector_o, vector_oe_o : interrupt vector and its bus enable
//   ocw2_change_ack_o     : one-cycle acknowledge of ocw2_change_i
//   status_o              : isr when ocw3[1:0]==2'b11, else irr
module pic_interrupt_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned VEC_BASE_BITS = 5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       init_done_i,
   input  logic [7:0] irr_i,
   input  logic [7:0] imr_i,
   input  logic [7:0] icw2_i,
   input  logic [7:0] icw4_i,
   input  logic [7:0] ocw2_i,
   input  logic       ocw2_change_i,
   input  logic [7:0] ocw3_i,
   input  logic       inta_n_i,
   output logic       int_o,
   output logic [7:0] irr_clr_o,
   output logic [7:0] isr_o,
   output logic [7:0] vector_o,
   output logic       vector_oe_o,
   output logic       ocw2_change_ack_o,
   output logic [7:0] status_o
);

   localparam int unsigned LoBits = 8 - VEC_BASE_BITS;
   localparam logic [7:0]  HiMask = 8'(8'hFF << LoBits);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inta_prev_q;
   logic                   inta_s, inta_fall, inta_rise;

   pic_state_e state_q, state_d;
   logic       int_q, int_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] irr_clr_q, irr_clr_d;
   logic [7:0] vector_q, vector_d;
   logic       oe_q, oe_d;
   logic       ack_q, ack_d;
   logic [2:0] w_q, w_d;
   logic       spur_q, spur_d;

   logic [7:0] req, isr_set, eoi_clr, aeoi_clr;
   logic       req_valid, isr_any, eoi_fire;
   logic [2:0] req_winner, isr_top, lowest_prio;
   logic       prio_upd, aeoi_upd;
   logic [2:0] prio_val;
   logic [7:0] vec_new;
   logic       unused_inputs;

   assign unused_inputs = ^{icw4_i[7:2], icw4_i[0], ocw3_i[7:2], ocw2_i[4:3]};

   // Synchroniser and edge detect on the synchronised acknowledge.
   assign inta_s    = sync_q[SYNC_STAGES-1];
   assign inta_fall = inta_prev_q & ~inta_s;
   assign inta_rise = ~inta_prev_q & inta_s;

   assign req = irr_i & ~imr_i;

   pic_priority_resolver u_req_resolver (
      .req_i         (req),
      .isr_i         (isr_q),
      .lowest_prio_i (lowest_prio),
      .valid_o       (req_valid),
      .winner_o      (req_winner)
   );

   // Same scan over the ISR alone yields its highest-priority set bit.
   pic_priority_resolver u_isr_resolver (
      .req_i         (isr_q),
      .isr_i         (8'h00),
      .lowest_prio_i (lowest_prio),
      .valid_o       (isr_any),
      .winner_o      (isr_top)
   );

   assign vec_new = (icw2_i & HiMask) | ({5'b0, w_q} & ~HiMask);

   // OCW2 decode; only one decode per rising of the change flag.
   always_comb begin
      eoi_fire = ocw2_change_i & ~ack_q;
      ack_d    = eoi_fire;
      eoi_clr  = '0;
      prio_upd = 1'b0;
      prio_val = '0;
      if (eoi_fire) begin
         case (ocw2_i[7:5])
            EOI_NS: if (isr_any) eoi_clr[isr_top] = 1'b1;
            EOI_SP: eoi_clr[ocw2_i[2:0]] = 1'b1;
`ifdef PIC_ROTATE_PRIORITY_EN
            ROT_NS: begin
               if (isr_any) begin
                  eoi_clr[isr_top] = 1'b1;
                  prio_upd         = 1'b1;
                  prio_val         = isr_top;
               end
            end
            ROT_SP: begin
               eoi_clr[ocw2_i[2:0]] = 1'b1;
               prio_upd             = 1'b1;
               prio_val             = ocw2_i[2:0];
            end
            SET_PRI: begin
               prio_upd = 1'b1;
               prio_val = ocw2_i[2:0];
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      int_d     = int_q;
      isr_set   = '0;
      aeoi_clr  = '0;
      aeoi_upd  = 1'b0;
      irr_clr_d = '0;
      vector_d  = vector_q;
      oe_d      = oe_q;
      w_d       = w_q;
      spur_d    = spur_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StPend;
               int_d   = 1'b1;
            end
         end
         StPend: begin
            if (inta_fall) begin
               state_d = StAck1;
               if (req_valid) begin
                  w_d                   = req_winner;
                  spur_d                = 1'b0;
                  isr_set[req_winner]   = 1'b1;
                  irr_clr_d[req_winner] = 1'b1;
               end else begin
                  w_d    = SPURIOUS_IR;
                  spur_d = 1'b1;
               end
            end
         end
         StAck1: begin
            if (inta_fall) begin
               state_d  = StAck2;
               vector_d = vec_new;
               oe_d     = 1'b1;
            end
         end
         StAck2: begin
            if (inta_rise) begin
               state_d = StIdle;
               oe_d    = 1'b0;
               int_d   = 1'b0;
               if (icw4_i[AEOI_BIT] && !spur_q) begin
                  aeoi_clr[w_q] = 1'b1;
                  aeoi_upd      = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Clears act on the pre-set ISR, so a set on the same bit wins.
      isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;

      if (!init_done_i) begin
         state_d   = StIdle;
         int_d     = 1'b0;
         oe_d      = 1'b0;
         isr_d     = '0;
         irr_clr_d = '0;
      end
   end

`ifdef PIC_ROTATE_PRIORITY_EN
   logic [2:0] lowest_prio_q, lowest_prio_d;

   always_comb begin
      lowest_prio_d = lowest_prio_q;
      if (aeoi_upd) begin
         lowest_prio_d = w_q;
      end else if (prio_upd) begin
         lowest_prio_d = prio_val;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lowest_prio_q <= 3'd7;
      else         lowest_prio_q <= lowest_prio_d;
   end

   assign lowest_prio = lowest_prio_q;
`else
   logic unused_prio;
   assign unused_prio = ^{prio_upd, prio_val, aeoi_upd};
   assign lowest_prio = 3'd7;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q      <= '1;
         inta_prev_q <= 1'b1;
         state_q     <= StIdle;
         int_q       <= 1'b0;
         isr_q       <= '0;
         irr_clr_q   <= '0;
         vector_q    <= '0;
         oe_q        <= 1'b0;
         ack_q       <= 1'b0;
         w_q         <= '0;
         spur_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], inta_n_i};
         inta_prev_q <= inta_s;
         state_q     <= state_d;
         int_q       <= int_d;
         isr_q       <= isr_d;
         irr_clr_q   <= irr_clr_d;
         vector_q    <= vector_d;
         oe_q        <= oe_d;
         ack_q       <= ack_d;
         w_q         <= w_d;
         spur_q      <= spur_d;
      end
   end

   assign int_o             = int_q;
   assign irr_clr_o         = irr_clr_q;
   assign isr_o             = isr_q;
   assign vector_o          = vector_q;
   assign vector_oe_o       = oe_q;
   assign ocw2_change_ack_o = ack_q;
   assign status_o          = (ocw3_i[1:0] == 2'b11) ? isr_q : irr_i;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench for pic_interrupt_sequencer (default build, fixed priority).
module tb_pic_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, init_done, ocw2_change, inta_n;
   logic [7:0] irr, imr, icw2, icw4, ocw2, ocw3;
   logic       int_out, vector_oe, ack;
   logic [7:0] irr_clr, isr, vector, status;

   int n_checks = 0;
   int n_fail   = 0;

   // Pulse monitors: counts, last value and longest high run.
   int         clr_cnt = 0, clr_run = 0, clr_max = 0;
   logic [7:0] clr_last = 8'h00;
   int         ack_cnt = 0, ack_run = 0, ack_max = 0;
   int         c0, a0;

   always #5 clk = ~clk;

   pic_interrupt_sequencer dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .init_done_i       (init_done),
      .irr_i             (irr),
      .imr_i             (imr),
      .icw2_i            (icw2),
      .icw4_i            (icw4),
      .ocw2_i            (ocw2),
      .ocw2_change_i     (ocw2_change),
      .ocw3_i            (ocw3),
      .inta_n_i          (inta_n),
      .int_o             (int_out),
      .irr_clr_o         (irr_clr),
      .isr_o             (isr),
      .vector_o          (vector),
      .vector_oe_o       (vector_oe),
      .ocw2_change_ack_o (ack),
      .status_o          (status)
   );

   always @(negedge clk) begin
      if (irr_clr != 8'h00) begin
         clr_cnt  = clr_cnt + 1;
         clr_last = irr_clr;
         clr_run  = clr_run + 1;
         if (clr_run > clr_max) clr_max = clr_run;
      end else begin
         clr_run = 0;
      end
      if (ack) begin
         ack_cnt = ack_cnt + 1;
         ack_run = ack_run + 1;
         if (ack_run > ack_max) ack_max = ack_run;
      end else begin
         ack_run = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic ocw2_write(input logic [7:0] val);
      ocw2        = val;
      ocw2_change = 1'b1;
      step(1);
      chk("ack_high", {7'b0, ack}, 8'h01);
      ocw2_change = 1'b0;
      step(1);
      chk("ack_low", {7'b0, ack}, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0; init_done = 1'b0; inta_n = 1'b1; ocw2_change = 1'b0;
      irr = 8'h00; imr = 8'h00; icw2 = 8'h40; icw4 = 8'h00; ocw2 = 8'h00; ocw3 = 8'h00;
      step(2);
      chk("rst_int", {7'b0, int_out}, 8'h00);
      chk("rst_isr", isr, 8'h00);
      chk("rst_vector", vector, 8'h00);
      chk("rst_oe", {7'b0, vector_oe}, 8'h00);
      chk("rst_irr_clr", irr_clr, 8'h00);
      chk("rst_ack", {7'b0, ack}, 8'h00);

      // Basic acknowledge of IR3.
      rst_n = 1'b1; init_done = 1'b1; irr = 8'h08;
      step(2);
      chk("ir3_int", {7'b0, int_out}, 8'h01);
      c0 = clr_cnt;
      inta_n = 1'b0; step(4);
      chk("ir3_isr", isr, 8'h08);
      chk("ir3_clr_cnt", 8'(clr_cnt - c0), 8'h01);
      chk("ir3_clr_val", clr_last, 8'h08);
      chk("ir3_oe_p1", {7'b0, vector_oe}, 8'h00);
      irr = 8'h00;
      inta_n = 1'b1; step(4);
      chk("ir3_oe_gap", {7'b0, vector_oe}, 8'h00);
      chk("ir3_int_gap", {7'b0, int_out}, 8'h01);
      inta_n = 1'b0; step(4);
      chk("ir3_vector", vector, 8'h43);
      chk("ir3_oe_p2", {7'b0, vector_oe}, 8'h01);
      inta_n = 1'b1; step(4);
      chk("ir3_oe_end", {7'b0, vector_oe}, 8'h00);
      chk("ir3_int_end", {7'b0, int_out}, 8'h00);
      chk("ir3_isr_end", isr, 8'h08);

      // Status select.
      ocw3 = 8'h03; #1;
      chk("status_isr", status, 8'h08);
      ocw3 = 8'h00;

      // Nesting: IR5 blocked by IR3 in service, IR1 preempts.
      irr = 8'h20; step(3);
      chk("status_irr", status, 8'h20);
      chk("nest_blocked", {7'b0, int_out}, 8'h00);
      irr = 8'h22; step(2);
      chk("nest_int", {7'b0, int_out}, 8'h01);
      inta_n = 1'b0; step(4);
      chk("nest_isr", isr, 8'h0A);
      chk("nest_clr_val", clr_last, 8'h02);
      irr = 8'h00;
      inta_n = 1'b1; step(4);
      inta_n = 1'b0; step(4);
      chk("nest_vector", vector, 8'h41);
      inta_n = 1'b1; step(4);
      chk("nest_int_end", {7'b0, int_out}, 8'h00);

      // EOI handling.
      a0 = ack_cnt;
      ocw2_write(8'h20);
      chk("eoi_ns_isr", isr, 8'h08);
      chk("eoi_ack_cnt", 8'(ack_cnt - a0), 8'h01);
      ocw2_write(8'hA0);
      chk("rot_ignored_isr", isr, 8'h08);
      ocw2_write(8'h63);
      chk("eoi_sp_isr", isr, 8'h00);

      // AEOI on IR0.
      icw4 = 8'h03; irr = 8'h01; step(2);
      chk("aeoi_int", {7'b0, int_out}, 8'h01);
      inta_n = 1'b0; step(4);
      chk("aeoi_isr_set", isr, 8'h01);
      irr = 8'h00;
      inta_n = 1'b1; step(4);
      inta_n = 1'b0; step(4);
      chk("aeoi_vector", vector, 8'h40);
      chk("aeoi_isr_ack2", isr, 8'h01);
      inta_n = 1'b1; step(4);
      chk("aeoi_isr_clr", isr, 8'h00);
      chk("aeoi_int_end", {7'b0, int_out}, 8'h00);
      icw4 = 8'h00;

      // Spurious: request withdrawn before the first INTA.
      irr = 8'h04; step(2);
      chk("spur_int", {7'b0, int_out}, 8'h01);
      irr = 8'h00; step(1);
      chk("spur_int_hold", {7'b0, int_out}, 8'h01);
      c0 = clr_cnt;
      inta_n = 1'b0; step(4);
      chk("spur_isr", isr, 8'h00);
      chk("spur_clr_cnt", 8'(clr_cnt - c0), 8'h00);
      inta_n = 1'b1; step(4);
      inta_n = 1'b0; step(4);
      chk("spur_vector", vector, 8'h47);
      inta_n = 1'b1; step(4);
      chk("spur_int_end", {7'b0, int_out}, 8'h00);
      chk("spur_isr_end", isr, 8'h00);

      // init_done drop mid-sequence.
      irr = 8'h10; step(2);
      inta_n = 1'b0; step(4);
      chk("idrop_isr_set", isr, 8'h10);
      init_done = 1'b0; step(1);
      chk("idrop_isr", isr, 8'h00);
      chk("idrop_int", {7'b0, int_out}, 8'h00);
      irr = 8'h00; inta_n = 1'b1; init_done = 1'b1; step(4);
      chk("idrop_idle", {7'b0, int_out}, 8'h00);

      // Asynchronous reset in ACK1.
      irr = 8'h02; step(2);
      inta_n = 1'b0; step(4);
      chk("rst1_isr_set", isr, 8'h02);
      rst_n = 1'b0; #1;
      chk("rst1_int", {7'b0, int_out}, 8'h00);
      chk("rst1_isr", isr, 8'h00);
      chk("rst1_oe", {7'b0, vector_oe}, 8'h00);
      irr = 8'h00; inta_n = 1'b1; step(2);
      rst_n = 1'b1; step(4);
      chk("rst1_idle", {7'b0, int_out}, 8'h00);
      irr = 8'h02; step(2);
      chk("rst1_restart", {7'b0, int_out}, 8'h01);

      chk("clr_max_run", 8'(clr_max), 8'h01);
      chk("ack_max_run", 8'(ack_max), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
Clocked control stage that consumes the command words and OCW2-change flag produced by the PIC read/write command decoder, together with the IRR contents. It resolves priority against IMR and ISR (fully nested mode) and raises INT. It then runs the 8086-mode two-pulse INTA sequence, drives the interrupt vector, and maintains ISR, including EOI/AEOI handling and the OCW2-change acknowledge handshake.

Parameters:
SYNC_STAGES, 2, flops in the inta_n synchroniser (minimum 2)
VEC_BASE_BITS, 5, number of ICW2 MSBs forming the vector base (T7..T3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_done  in  1  ICW sequence complete; 0 holds the block idle
irr  in  8  interrupt request register contents
imr  in  8  mask (OCW1); 1 = masked
icw2  in  8  vector base
icw4  in  8  bit1 = AEOI
ocw2  in  8  operation command word 2
ocw2_change  in  1  level flag: OCW2 newly written
ocw3  in  8  bits[1:0] = RR/RIS status select
inta_n  in  1  asynchronous CPU interrupt acknowledge, active low
int_out  out  1  interrupt request to CPU
irr_clr  out  8  one-cycle pulse; clears the acknowledged IRR bit
isr  out  8  in-service register
vector  out  8  interrupt vector
vector_oe  out  1  drive vector onto the data bus
ocw2_change_ack  out  1  one-cycle pulse acknowledging ocw2_change
status_out  out  8  ocw3[1:0]==2'b11 selects isr, otherwise irr

Behaviour:
- Reset (async, rst_n=0): state=IDLE, int_out=0, isr=0, irr_clr=0, vector=0, vector_oe=0, ocw2_change_ack=0, synchroniser flops=1.
- inta_n passes through SYNC_STAGES flops; fall/rise edges are detected on the synchronised copy.
- req = irr & ~imr. The winner is the lowest-index set bit of req (IR0 highest). It is eligible only if its priority is strictly higher than the highest set isr bit.
- FSM states: IDLE, PEND, ACK1, ACK2.
- IDLE: eligible winner and init_done=1 -> PEND; int_out=1 from the next cycle.
- PEND: on synced INTA fall -> latch winner, isr[w]<=1, irr_clr[w] pulses 1 cycle -> ACK1.
- PEND, spurious case: if no eligible request at the INTA fall, latch w=7 with the spurious flag set; isr and irr_clr are untouched.
- ACK1: on synced INTA fall -> ACK2, vector={icw2[7:3],w[2:0]}, vector_oe=1 while synced inta_n=0.
- ACK2: on synced INTA rise -> vector_oe=0, int_out=0, IDLE; if icw4[1]=1 and not spurious, clear isr[w] in the same cycle.
- PEND with request withdrawn and no INTA yet: int_out stays 1 (the CPU will acknowledge; the spurious path handles it).
- EOI decode: when ocw2_change=1 and ocw2_change_ack was 0 last cycle, pulse ocw2_change_ack for 1 cycle and decode ocw2[7:5]:
  - 001 non-specific EOI: clear the highest-priority set isr bit.
  - 011 specific EOI: clear isr[ocw2[2:0]].
  - Other codes: no effect (unless the optional feature is compiled in).
- Simultaneous ISR set (ACK1 entry) and EOI clear in one cycle: clear is computed on the pre-set isr; set wins on the same bit.
- init_done falling to 0 mid-sequence: FSM->IDLE, int_out=0, vector_oe=0, isr=0 next cycle.
- irr_clr and ocw2_change_ack are never high for more than 1 cycle.

Optional Feature:
PIC_ROTATE_PRIORITY_EN
- Defined: adds an internal 3-bit lowest_prio register, reset value 7.
  - Priority order becomes (lowest_prio+1) mod 8 highest, wrapping around.
  - OCW2 101: rotate on non-specific EOI; lowest_prio = cleared bit.
  - OCW2 111: rotate on specific EOI; clear isr[L], lowest_prio=L.
  - OCW2 110: set priority; lowest_prio=ocw2[2:0], isr unchanged.
  - With icw4[1]=1 (AEOI), lowest_prio is set to w at the AEOI clear (rotate in AEOI).
- Undefined: fixed priority; codes 101/110/111 are acknowledged but ignored.

Decomposition:
- Package pic_pkg holds:
  - FSM state enum.
  - OCW2 command code constants (EOI_NS=3'b001, EOI_SP=3'b011, ROT_NS=3'b101, SET_PRI=3'b110, ROT_SP=3'b111).
  - AEOI bit index and SPURIOUS_IR=3'd7.
- One combinational sub-module, pic_priority_resolver: inputs req, isr, lowest_prio; outputs valid and winner index.

Test Plan:
- Reset asserted mid-ACK1 -> int_out=0, isr=8'h00, vector_oe=0 immediately; FSM returns to IDLE.
- icw2=8'h40, irr=8'h08, imr=0, init_done=1 -> int_out=1; two INTA pulses -> irr_clr=8'h08 (1 cycle), isr=8'h08, vector=8'h43 with vector_oe=1 only during the second pulse.
- Nested: isr=8'h08; irr=8'h20 -> int_out stays 0; irr=8'h22 -> int_out=1, vector=8'h41.
- ocw2=8'h20 with ocw2_change=1 -> one ack pulse, isr 8'h28->8'h20; ocw2=8'h65 -> isr 8'h20->8'h00.
- icw4=8'h03, irr=8'h01 -> after the second INTA rise isr=8'h00, vector=8'h40.
- irr drops to 0 before the first INTA -> vector=8'h47, isr unchanged, irr_clr=0.
